// File: rtl/shift_sequencer.sv
// shift_sequencer: initiator for the registered 32-bit shifter command port.
//
// Accepts one request (mode, 0-31 bit amount, 32-bit operand), issues a LOAD
// followed by ceil(amount/3) shift commands of at most 3 bits each, captures
// the shifter output and returns it with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock, shared with the shifter
//   reset     synchronous, active-high reset
//   start     request strobe, sampled only in idle
//   mode      00 LSL, 01 LSR, 10 ASR, 11 pass-through (load only)
//   amount    total shift distance, 0-31
//   data      operand
//   busy      high while a request is in progress
//   done      one-cycle pulse when result is valid
//   result    final shifted value, held until the next done
//   sh_op     shifter command: 000 NOP, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
//   sh_shamt  per-command shift distance, 0-3
//   sh_d_in   operand presented to the shifter (meaningful during LOAD)
//   sh_d_out  shifter register contents
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [4:0]  amount,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [2:0]  sh_op,
  output logic [1:0]  sh_shamt,
  output logic [31:0] sh_d_in,
  input  logic [31:0] sh_d_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCapture} state_e;

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpLoad = 3'b001;
  localparam logic [2:0] OpLsl  = 3'b010;
  localparam logic [2:0] OpLsr  = 3'b011;
  localparam logic [2:0] OpAsr  = 3'b100;

  state_e      state_q;
  logic [1:0]  mode_q;
  logic [4:0]  rem_q;
  logic [31:0] data_q;
  logic [1:0]  step;

  // Distance carried by the current shift command: full 3-bit steps, last one
  // carries the remainder.
  assign step = (rem_q >= 5'd3) ? 2'd3 : rem_q[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      rem_q   <= 5'd0;
      data_q  <= 32'h0000_0000;
      result  <= 32'h0000_0000;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            mode_q  <= mode;
            // Pass-through only loads, so no shift distance is kept.
            rem_q   <= (mode == 2'b11) ? 5'd0 : amount;
            data_q  <= data;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          state_q <= (rem_q != 5'd0) ? StShift : StCapture;
        end
        StShift: begin
          rem_q <= rem_q - {3'b000, step};
          if (rem_q == {3'b000, step}) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          result  <= sh_d_out;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Command decode depends only on registered state.
  always_comb begin
    sh_op    = OpNop;
    sh_shamt = 2'b00;
    case (state_q)
      StLoad: sh_op = OpLoad;
      StShift: begin
        sh_shamt = step;
        case (mode_q)
          2'b00:   sh_op = OpLsl;
          2'b01:   sh_op = OpLsr;
          2'b10:   sh_op = OpAsr;
          default: sh_op = OpNop;
        endcase
      end
      default: begin
        sh_op    = OpNop;
        sh_shamt = 2'b00;
      end
    endcase
  end

  assign sh_d_in = data_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer with a behavioural
// registered shifter attached to the command port.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  amount;
  logic [31:0] data;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [2:0]  sh_op;
  logic [1:0]  sh_shamt;
  logic [31:0] sh_d_in;
  logic [31:0] sh_d_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] op_log [64];
  logic [1:0] sh_log [64];

  always #5 clk = ~clk;

  shift_sequencer u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .amount   (amount),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .sh_op    (sh_op),
    .sh_shamt (sh_shamt),
    .sh_d_in  (sh_d_in),
    .sh_d_out (sh_d_out)
  );

  // Registered shifter model.
  always @(posedge clk) begin
    if (reset) begin
      sh_d_out <= 32'h0;
    end else begin
      case (sh_op)
        3'b001:  sh_d_out <= sh_d_in;
        3'b010:  sh_d_out <= sh_d_out << sh_shamt;
        3'b011:  sh_d_out <= sh_d_out >> sh_shamt;
        3'b100:  sh_d_out <= $unsigned($signed(sh_d_out) >>> sh_shamt);
        default: sh_d_out <= sh_d_out;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Launch a request on the next edge and follow it to done. Leaves the bench
  // 1 time unit after the done edge, so a caller may start back-to-back.
  task automatic do_req(input string tag, input logic [1:0] m, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_lat,
                        input bit poke);
    int cyc;
    int busy_cnt;
    int overlap;
    logic [31:0] din0;
    start  = 1'b1;
    mode   = m;
    amount = a;
    data   = d;
    @(posedge clk);
    #1;
    start    = 1'b0;
    // Inputs may change freely after the sampling edge.
    mode     = 2'($urandom);
    amount   = 5'($urandom);
    data     = $urandom;
    din0     = sh_d_in;
    cyc      = 0;
    busy_cnt = 0;
    overlap  = 0;
    while (cyc < 40) begin
      op_log[cyc] = sh_op;
      sh_log[cyc] = sh_shamt;
      if (busy) busy_cnt++;
      if (poke && cyc == 1) begin
        start  = 1'b1;
        mode   = 2'b00;
        amount = 5'd1;
        data   = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (busy && done) overlap++;
      if (done) break;
    end
    check_eq({tag, "_done_seen"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_latency"}, cyc, exp_lat);
    check_eq({tag, "_result"}, result, exp);
    check_eq({tag, "_busy_cycles"}, busy_cnt, exp_lat);
    check_eq({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_overlap"}, overlap, 0);
    check_eq({tag, "_load_op"}, {29'b0, op_log[0]}, 32'd1);
    check_eq({tag, "_load_din"}, din0, d);
    check_eq({tag, "_capture_op"}, {29'b0, op_log[exp_lat-1]}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    mode   = 2'b00;
    amount = 5'd5;
    data   = 32'h1234_5678;

    // Reset held two cycles with start asserted.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_done", {31'b0, done}, 32'd0);
      check_eq("rst_result", result, 32'h0);
      check_eq("rst_sh_op", {29'b0, sh_op}, 32'd0);
      check_eq("rst_sh_shamt", {30'b0, sh_shamt}, 32'd0);
      check_eq("rst_sh_d_in", sh_d_in, 32'h0);
    end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    // LSL 4: LOAD, LSL/3, LSL/1, NOP.
    do_req("lsl4", 2'b00, 5'd4, 32'h0111_0111, 32'h1110_1110, 4, 1'b0);
    check_eq("lsl4_op1", {29'b0, op_log[1]}, 32'd2);
    check_eq("lsl4_sh1", {30'b0, sh_log[1]}, 32'd3);
    check_eq("lsl4_op2", {29'b0, op_log[2]}, 32'd2);
    check_eq("lsl4_sh2", {30'b0, sh_log[2]}, 32'd1);
    @(negedge clk);

    // ASR 31: ten 3-bit steps then one 1-bit step.
    do_req("asr31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 13, 1'b0);
    check_eq("asr31_op1", {29'b0, op_log[1]}, 32'd4);
    check_eq("asr31_sh10", {30'b0, sh_log[10]}, 32'd3);
    check_eq("asr31_op11", {29'b0, op_log[11]}, 32'd4);
    check_eq("asr31_sh11", {30'b0, sh_log[11]}, 32'd1);
    @(negedge clk);

    // Zero distance and pass-through.
    do_req("lsr0", 2'b01, 5'd0, 32'h1000_0110, 32'h1000_0110, 2, 1'b0);
    @(negedge clk);
    do_req("pass9", 2'b11, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 1'b0);
    @(negedge clk);

    // LSR 5 with an ignored start during busy, then a back-to-back ASR 7.
    do_req("lsr5", 2'b01, 5'd5, 32'h1000_0110, 32'h0080_0008, 4, 1'b1);
    do_req("b2b_asr7", 2'b10, 5'd7, 32'hF000_0000, 32'hFFE0_0000, 5, 1'b0);
    @(negedge clk);

    // Reset in the third SHIFT cycle of LSL 31.
    start  = 1'b1;
    mode   = 2'b00;
    amount = 5'd31;
    data   = 32'h0000_0001;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("mid_pre_shift_op", {29'b0, sh_op}, 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_busy", {31'b0, busy}, 32'd0);
    check_eq("mid_result", result, 32'h0);
    check_eq("mid_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    begin
      int dcnt = 0;
      for (int i = 0; i < 16; i++) begin
        @(posedge clk);
        #1;
        if (done || busy) dcnt++;
      end
      check_eq("mid_no_done", dcnt, 0);
    end
    do_req("post_lsl31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000, 13, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that drives the op/shamt/d_in command port of the team's registered 32-bit shifter (shifter32) and reads its d_out back. It accepts a single request: mode, a 0–31 bit amount and a 32-bit operand. It then issues one LOAD followed by as many 0–3-bit shift commands as needed, captures the shifter output and returns the result with a one-cycle done pulse. It is the initiator side of the shifter command interface, placed between the datapath control and a shifter32 instance.

## Interface
Parameters:
- none (widths fixed by the shifter32 command port: 3-bit op, 2-bit shamt, 32-bit data)

Ports:
- clk  in  1  rising-edge clock, shared with the shifter32 instance
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- mode  in  2  00 LSL, 01 LSR, 10 ASR, 11 pass-through (load only)
- amount  in  5  total shift distance, 0–31
- data  in  32  operand
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  32  final shifted value; holds until the next done
- sh_op  out  3  shifter command: 000 NOP/hold, 001 LOAD, 010 LSL, 011 LSR, 100 ASR
- sh_shamt  out  2  per-command shift distance, 0–3 bits
- sh_d_in  out  32  operand presented to the shifter during LOAD
- sh_d_out  in  32  shifter register contents (registered in the shifter)

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE.
- **IDLE:** sh_op=000, sh_shamt=00. On start=1, latch mode, amount and data into mode_q, rem_q and data_q, then go to LOAD. For mode 11, rem_q is forced to 0.
- **LOAD:** sh_op=001, sh_d_in=data_q. Go to SHIFT if rem_q≠0, otherwise go to CAPTURE.
- **SHIFT:**
  - sh_op is 010, 011 or 100 for mode 00, 01 or 10 respectively.
  - sh_shamt=min(3, rem_q), and rem_q decrements by sh_shamt each cycle.
  - Go to CAPTURE when rem_q−sh_shamt=0.
- **Step count:** k=ceil(amount/3). Every step is 3 bits except the last, which carries the remainder.
- **CAPTURE:** sh_op=000. result<=sh_d_out, done<=1, then go to IDLE.
- **Output decode:** sh_op, sh_shamt and sh_d_in decode from registered state only; there is no combinational path from start, mode, amount or data.
- sh_d_in equals data_q in all states. It is meaningful only in LOAD.
- ASR correctness depends on the shifter replicating bit 31; the sequencer does no sign handling.

## Timing
- Let E0 be the clock edge that samples start in IDLE.
  - LOAD occupies the cycle after E0.
  - SHIFT occupies k cycles.
  - CAPTURE occupies one cycle.
  - done=1 and the updated result are visible after edge E(k+2).
- busy rises after E0 and falls after E(k+2), in the same cycle done rises. busy is never high while done is high.
- Latency from start to done: amount 0 or mode 11 gives 2 cycles; amount 31 gives 13 cycles.
- start while busy=1 is ignored. No queuing; the inputs are not re-sampled.
- start in the cycle that done is high is accepted, because the state is already IDLE. This gives back-to-back requests with no gap cycle.
- The mode, amount and data inputs may change freely after E0.
- **Reset values (all at the next edge with reset=1):** state IDLE, busy 0, done 0, result 32'h0000_0000, sh_op 000, sh_shamt 00, rem_q 0, data_q 0, so sh_d_in 0.
- **Reset mid-operation** (any state): abort immediately at the next edge. No done pulse; result=0.
- The shifter's own reset is independent. Every request starts with LOAD, so stale shifter contents never affect result.
- reset has priority over start in the same cycle.

## Test plan
- **Reset:** hold reset 2 cycles with start=1 -> busy=0, done=0, result=0, sh_op=000, sh_shamt=00 throughout.
- **LSL 4, data 32'h0111_0111:**
  - sh_op sequence 001, 010/3, 010/1, 000.
  - result=32'h1110_1110.
  - done pulses after E4.
- **ASR 31, data 32'h8000_0000:**
  - 10 steps of shamt 3 followed by 1 step of shamt 1.
  - result=32'hFFFF_FFFF.
  - done after E13.
  - busy high for exactly 13 cycles.
- **Zero distance:**
  - LSR 0, data 32'h1000_0110 -> sh_op 001, 000; result=32'h1000_0110; done after E2.
  - mode 11 with amount 9 -> same timing; result=data.
- **Busy and back-to-back handling:**
  - LSR 5, data 32'h1000_0110 -> result 32'h0080_0008.
  - A second start during busy is ignored.
  - A new start in the done cycle launches immediately with the correct second result.
- **Reset mid-SHIFT:** during LSL 31, assert reset in the third SHIFT cycle -> busy=0 and result=0 at the next edge; done never pulses. A following request completes normally.
